// File: rtl/black_box_pipe_pkg.sv
// black_box_pipe_pkg: op selection enum, OP-string decoder and the
// single-cycle arithmetic applied in front of the first pipeline stage.
package black_box_pipe_pkg;

    // apply_op works on a fixed-width container. Callers zero-extend their
    // operands and truncate the result. The low WIDTH bits of PASS, INVERT,
    // ADD and SUB depend only on the low WIDTH bits of the operands, so the
    // truncated result is exactly the mod-2^WIDTH answer. WIDTH may be at
    // most MAX_WIDTH.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        OP_PASS,
        OP_INVERT,
        OP_ADD,
        OP_SUB
    } op_e;

    // An unrecognised OP string falls back to PASS.
    function automatic op_e op_from_string(input string s);
        if (s == "INVERT") return OP_INVERT;
        if (s == "ADD")    return OP_ADD;
        if (s == "SUB")    return OP_SUB;
        return OP_PASS;
    endfunction

    // Carry and borrow out of the container are discarded.
    function automatic logic [MAX_WIDTH-1:0] apply_op(
        input op_e                  op,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b
    );
        logic [MAX_WIDTH-1:0] r;
        case (op)
            OP_INVERT: r = ~a;
            OP_ADD:    r = a + b;
            OP_SUB:    r = a - b;
            default:   r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/black_box_pipe_stage.sv
// black_box_pipe_stage: one elastic register slot (valid bit + data) with a
// valid/ready handshake on both sides. It can accept a new beat whenever it
// is empty or its current beat leaves in the same cycle.
module black_box_pipe_stage
    import black_box_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Valid follows the upstream offer whenever the slot is free to change.
    // Data loads only on an accepted beat, so an empty slot keeps the last
    // value it held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (in_ready) begin
                valid_q <= in_valid;
            end
            if (in_valid && in_ready) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/black_box_pipe.sv
// black_box_pipe: a single-cycle op (PASS/INVERT/ADD/SUB, chosen by the OP
// string) followed by DEPTH elastic stages. The ready chain is combinational
// from out_ready back to in_ready, which gives full throughput.
// Optional feature: define BLACK_BOX_PIPE_COUNT_EN to add the registered
// occupancy output `count`.
module black_box_pipe
    import black_box_pipe_pkg::*;
#(
    parameter int    WIDTH = 16,
    parameter int    DEPTH = 2,
    parameter string OP    = "PASS"
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data
`ifdef BLACK_BOX_PIPE_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

    op_e              op_sel;
    logic [WIDTH-1:0] op_result;

    assign op_sel    = op_from_string(OP);
    assign op_result = WIDTH'(apply_op(op_sel, MAX_WIDTH'(in_a), MAX_WIDTH'(in_b)));

    // Each generate scope owns its link signals and reaches its neighbours
    // by name. This keeps the combinational ready chain from folding onto a
    // single shared array.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             up_ready;
        logic             dn_ready;
        logic             v;
        logic [WIDTH-1:0] d;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = op_result;
        end else begin : g_link
            assign up_valid = g_stage[i-1].v;
            assign up_data  = g_stage[i-1].d;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_next
            assign dn_ready = g_stage[i+1].up_ready;
        end

        black_box_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .in_valid (up_valid),
            .in_ready (up_ready),
            .in_data  (up_data),
            .out_valid(v),
            .out_ready(dn_ready),
            .out_data (d)
        );
    end

    assign in_ready  = g_stage[0].up_ready;
    assign out_valid = g_stage[DEPTH-1].v;
    assign out_data  = g_stage[DEPTH-1].d;

`ifdef BLACK_BOX_PIPE_COUNT_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Occupancy: a push adds one, a pop removes one, both together cancel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_black_box_pipe.sv
// tb_black_box_pipe: directed checks of black_box_pipe. The main instance is
// ADD/DEPTH=2. Side instances cover SUB (DEPTH=1), INVERT (DEPTH=3) and an
// unknown OP string (DEPTH=2). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_black_box_pipe;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    logic        v_sub, r_sub, ov_sub;
    logic [15:0] od_sub;
    logic        v_inv, r_inv, ov_inv;
    logic [15:0] od_inv;
    logic        v_bog, r_bog, ov_bog;
    logic [15:0] od_bog;

`ifdef BLACK_BOX_PIPE_COUNT_EN
    logic [1:0] count;
    logic       cnt_sub;
    logic [1:0] cnt_inv;
    logic [1:0] cnt_bog;
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0] q[$];

    black_box_pipe #(.WIDTH(16), .DEPTH(2), .OP("ADD")) dut (
`ifdef BLACK_BOX_PIPE_COUNT_EN
        .count(count),
`endif
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    black_box_pipe #(.WIDTH(16), .DEPTH(1), .OP("SUB")) dut_sub (
`ifdef BLACK_BOX_PIPE_COUNT_EN
        .count(cnt_sub),
`endif
        .clock(clock), .reset(reset), .in_valid(v_sub), .in_ready(r_sub),
        .in_a(in_a), .in_b(in_b), .out_valid(ov_sub), .out_ready(1'b1),
        .out_data(od_sub)
    );

    black_box_pipe #(.WIDTH(16), .DEPTH(3), .OP("INVERT")) dut_inv (
`ifdef BLACK_BOX_PIPE_COUNT_EN
        .count(cnt_inv),
`endif
        .clock(clock), .reset(reset), .in_valid(v_inv), .in_ready(r_inv),
        .in_a(in_a), .in_b(in_b), .out_valid(ov_inv), .out_ready(1'b1),
        .out_data(od_inv)
    );

    black_box_pipe #(.WIDTH(16), .DEPTH(2), .OP("bogus")) dut_bog (
`ifdef BLACK_BOX_PIPE_COUNT_EN
        .count(cnt_bog),
`endif
        .clock(clock), .reset(reset), .in_valid(v_bog), .in_ready(r_bog),
        .in_a(in_a), .in_b(in_b), .out_valid(ov_bog), .out_ready(1'b1),
        .out_data(od_bog)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
        v_sub = 1'b0; v_inv = 1'b0; v_bog = 1'b0;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef BLACK_BOX_PIPE_COUNT_EN
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
`endif
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL idle_handshake got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
`ifdef BLACK_BOX_PIPE_COUNT_EN
            checks++; if (count !== 2'd0) begin errors++; $display("FAIL idle_count got %0d want 0", count); end
`endif
        end
    endtask

    task automatic test_add();
        @(negedge clock);
        in_valid = 1'b1; in_a = 16'h0003; in_b = 16'h0004; out_ready = 1'b1;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency got v=%b want 0", out_valid); end
        in_a = 16'hFFFF; in_b = 16'h0002;
        @(negedge clock);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h0007) begin errors++; $display("FAIL add_first got v=%b d=%h want v=1 d=0007", out_valid, out_data); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h0001) begin errors++; $display("FAIL add_wrap got v=%b d=%h want v=1 d=0001", out_valid, out_data); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0001) begin errors++; $display("FAIL add_empty_hold got v=%b d=%h want v=0 d=0001", out_valid, out_data); end
    endtask

    task automatic test_ops();
        checks++; if ({r_sub, r_inv, r_bog} !== 3'b111) begin errors++; $display("FAIL ops_idle_ready got %b want 111", {r_sub, r_inv, r_bog}); end
        in_a = 16'h0000; in_b = 16'h0001; v_sub = 1'b1;
        @(negedge clock);
        v_sub = 1'b0;
        checks++; if (ov_sub !== 1'b1 || od_sub !== 16'hFFFF) begin errors++; $display("FAIL sub_borrow got v=%b d=%h want v=1 d=ffff", ov_sub, od_sub); end
        @(negedge clock);
        checks++; if (ov_sub !== 1'b0) begin errors++; $display("FAIL sub_drain got v=%b want 0", ov_sub); end
        in_a = 16'h00FF; v_inv = 1'b1;
        @(negedge clock);
        v_inv = 1'b0;
        checks++; if (ov_inv !== 1'b0) begin errors++; $display("FAIL inv_latency1 got v=%b want 0", ov_inv); end
        @(negedge clock);
        checks++; if (ov_inv !== 1'b0) begin errors++; $display("FAIL inv_latency2 got v=%b want 0", ov_inv); end
        in_a = 16'h1234; in_b = 16'hFFFF; v_bog = 1'b1;
        @(negedge clock);
        v_bog = 1'b0;
        checks++; if (ov_inv !== 1'b1 || od_inv !== 16'hFF00) begin errors++; $display("FAIL inv_result got v=%b d=%h want v=1 d=ff00", ov_inv, od_inv); end
        checks++; if (ov_bog !== 1'b0) begin errors++; $display("FAIL bogus_latency got v=%b want 0", ov_bog); end
        @(negedge clock);
        checks++; if (ov_bog !== 1'b1 || od_bog !== 16'h1234) begin errors++; $display("FAIL bogus_pass got v=%b d=%h want v=1 d=1234", ov_bog, od_bog); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_a = 16'd1; in_b = 16'd0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
        @(negedge clock);
        in_a = 16'd2;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready2 got %b want 1", in_ready); end
        @(negedge clock);
        in_a = 16'd3;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd1) begin errors++; $display("FAIL bp_head got v=%b d=%h want v=1 d=0001", out_valid, out_data); end
`ifdef BLACK_BOX_PIPE_COUNT_EN
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL bp_count_full got %0d want 2", count); end
`endif
        @(negedge clock);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'd1) begin errors++; $display("FAIL bp_hold got r=%b v=%b d=%h want r=0 v=1 d=0001", in_ready, out_valid, out_data); end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_comb_ready got %b want 1", in_ready); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd2) begin errors++; $display("FAIL bp_second got v=%b d=%h want v=1 d=0002", out_valid, out_data); end
`ifdef BLACK_BOX_PIPE_COUNT_EN
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL bp_count_one got %0d want 1", count); end
`endif
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_third got v=%b want 0", out_valid); end
`ifdef BLACK_BOX_PIPE_COUNT_EN
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL bp_count_empty got %0d want 0", count); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [15:0] ra, rb;
        q.delete();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            in_a = ra; in_b = rb; q.push_back(ra + rb);
            @(negedge clock);
        end
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            in_a = ra; in_b = rb; out_ready = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_data !== q[0]) begin errors++; $display("FAIL b2b_data[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, q[0]); end
`ifdef BLACK_BOX_PIPE_COUNT_EN
            checks++; if (count !== 2'd2) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 2", i, count); end
`endif
            @(negedge clock);
            void'(q.pop_front());
            q.push_back(ra + rb);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== q[0]) begin errors++; $display("FAIL b2b_drain[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, q[0]); end
            @(negedge clock);
            void'(q.pop_front());
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got v=%b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0; in_valid = 1'b1; in_a = 16'd10; in_b = 16'd5;
        @(negedge clock);
        in_a = 16'd20;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin errors++; $display("FAIL midrst_out got v=%b d=%h want v=0 d=0000", out_valid, out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", in_ready); end
`ifdef BLACK_BOX_PIPE_COUNT_EN
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", count); end
`endif
        @(negedge clock);
        reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_a = 16'd7; in_b = 16'd1;
        @(negedge clock);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL postrst_latency got v=%b want 0", out_valid); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd8) begin errors++; $display("FAIL postrst_beat got v=%b d=%h want v=1 d=0008", out_valid, out_data); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL postrst_alone got v=%b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
